// File: rtl/bar_graph_pkg.sv
// Register map and mode encodings shared by the bar-graph controller and its bench.
package bar_graph_pkg;

    localparam int REG_CTRL      = 0;
    localparam int REG_PATTERN   = 1;
    localparam int REG_PRESCALE  = 2;
    localparam int REG_STATUS    = 3;
    localparam int REG_DUTY_BASE = 4;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_PWM    = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_CHASE  = 2'd3
    } mode_e;

endpackage

// File: rtl/bar_graph_pwm_wb_if.sv
// Wishbone slave-side bus bundle for the bar-graph controller.
interface bar_graph_pwm_wb_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] wbs_address;
    logic [DATA_WIDTH-1:0] wbs_writedata;
    logic [DATA_WIDTH-1:0] wbs_readdata;
    logic                  wbs_strobe;
    logic                  wbs_write;
    logic                  wbs_cycle;
    logic                  wbs_ack;

    modport master (
        output wbs_address, wbs_writedata, wbs_strobe, wbs_write, wbs_cycle,
        input  wbs_readdata, wbs_ack
    );

    modport slave (
        input  wbs_address, wbs_writedata, wbs_strobe, wbs_write, wbs_cycle,
        output wbs_readdata, wbs_ack
    );
endinterface

// File: rtl/pwm_timebase.sv
// Prescaler plus free-running PWM counter; tick marks a prescaler reload, wrap a counter rollover.
module pwm_timebase #(
    parameter int PRESCALE_WIDTH = 16,
    parameter int PWM_BITS       = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_enable,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    input  logic                      i_prescale_clr,
    output logic [PWM_BITS-1:0]       o_pwm_cnt,
    output logic                      o_tick,
    output logic                      o_wrap
);
    logic [PRESCALE_WIDTH-1:0] r_pre_cnt;
    logic [PWM_BITS-1:0]       r_pwm_cnt;
    logic                      w_tick;

    assign w_tick = i_enable && (r_pre_cnt == i_prescale);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset || !i_enable) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
        end else begin
            if (w_tick || i_prescale_clr) r_pre_cnt <= '0;
            else                          r_pre_cnt <= r_pre_cnt + 1'b1;
            if (w_tick) r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    assign o_pwm_cnt = r_pwm_cnt;
    assign o_tick    = w_tick;
    assign o_wrap    = w_tick && (&r_pwm_cnt);
endmodule

// File: rtl/bar_graph_pwm_wb.sv
// Wishbone LED bar-graph controller: static, PWM, blink and chase modes on a shared timebase.
module bar_graph_pwm_wb
    import bar_graph_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_LEDS       = 8,
    parameter int PWM_BITS       = 8,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    output logic [NUM_LEDS-1:0] bar_graph,
    bar_graph_pwm_wb_if.slave   wbs
);
    logic                      r_enable;
    mode_e                     r_mode;
    logic [NUM_LEDS-1:0]       r_pattern;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [PWM_BITS-1:0]       r_duty [NUM_LEDS];
    logic                      r_phase;
    logic [NUM_LEDS-1:0]       r_chase;
    logic                      r_ack;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic [NUM_LEDS-1:0]       r_bar;

    logic                  w_req, w_wr, w_rd;
    logic [NUM_LEDS-1:0]   w_duty_sel;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [NUM_LEDS-1:0]   w_bar_nxt;
    logic [PWM_BITS-1:0]   w_pwm_cnt;
    logic                  w_tick, w_wrap;
    mode_e                 w_wr_mode;

    assign w_req     = wbs.wbs_cycle && wbs.wbs_strobe && !r_ack;
    assign w_wr      = w_req && wbs.wbs_write;
    assign w_rd      = w_req && !wbs.wbs_write;
    assign w_wr_mode = mode_e'(wbs.wbs_writedata[2:1]);

    pwm_timebase #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .PWM_BITS       (PWM_BITS)
    ) u_timebase (
        .clk            (clk),
        .reset          (reset),
        .i_enable       (r_enable),
        .i_prescale     (r_prescale),
        .i_prescale_clr (w_wr && (wbs.wbs_address == ADDR_WIDTH'(REG_PRESCALE))),
        .o_pwm_cnt      (w_pwm_cnt),
        .o_tick         (w_tick),
        .o_wrap         (w_wrap)
    );

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_duty_sel = '0;
        for (int i = 0; i < NUM_LEDS; i++)
            w_duty_sel[i] = (wbs.wbs_address == ADDR_WIDTH'(REG_DUTY_BASE + i));
    end

    always_comb begin
        w_rdata = '0;
        case (wbs.wbs_address)
            ADDR_WIDTH'(REG_CTRL):     w_rdata[2:0]              = {r_mode, r_enable};
            ADDR_WIDTH'(REG_PATTERN):  w_rdata[NUM_LEDS-1:0]       = r_pattern;
            ADDR_WIDTH'(REG_PRESCALE): w_rdata[PRESCALE_WIDTH-1:0] = r_prescale;
            ADDR_WIDTH'(REG_STATUS):   w_rdata[PWM_BITS:0]         = {r_phase, w_pwm_cnt};
            default:
                for (int i = 0; i < NUM_LEDS; i++)
                    if (w_duty_sel[i]) w_rdata[PWM_BITS-1:0] = r_duty[i];
        endcase
    end

    always_comb begin
        w_bar_nxt = '0;
        if (r_enable) begin
            case (r_mode)
                MODE_STATIC: w_bar_nxt = r_pattern;
                MODE_PWM:
                    for (int i = 0; i < NUM_LEDS; i++)
                        w_bar_nxt[i] = r_pattern[i] && (r_duty[i] > w_pwm_cnt);
                MODE_BLINK:  w_bar_nxt = r_phase ? r_pattern : '0;
                default:     w_bar_nxt = r_chase;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_enable   <= 1'b0;
            r_mode     <= MODE_STATIC;
            r_pattern  <= '0;
            r_prescale <= '0;
            r_phase    <= 1'b0;
            r_chase    <= '0;
            r_ack      <= 1'b0;
            r_rdata    <= '0;
            r_bar      <= '0;
            // NOTE: the duty bank is a handful of flops, not a RAM, so it is cleared like any register.
            for (int i = 0; i < NUM_LEDS; i++) r_duty[i] <= '0;
        end else begin
            r_ack <= w_req;
            r_bar <= w_bar_nxt;
            if (w_rd) r_rdata <= w_rdata;
            if (w_tick && w_wrap) begin
                r_phase <= ~r_phase;
                r_chase <= {r_chase[NUM_LEDS-2:0], r_chase[NUM_LEDS-1]};
            end
            // A bus write below overrides the wrap update above for the same register.
            if (w_wr) begin
                case (wbs.wbs_address)
                    ADDR_WIDTH'(REG_CTRL): begin
                        r_enable <= wbs.wbs_writedata[0];
                        r_mode   <= w_wr_mode;
                        if (w_wr_mode == MODE_CHASE) r_chase <= r_pattern;
                    end
                    ADDR_WIDTH'(REG_PATTERN): begin
                        r_pattern <= wbs.wbs_writedata[NUM_LEDS-1:0];
                        if (r_mode == MODE_CHASE) r_chase <= wbs.wbs_writedata[NUM_LEDS-1:0];
                    end
                    ADDR_WIDTH'(REG_PRESCALE): r_prescale <= wbs.wbs_writedata[PRESCALE_WIDTH-1:0];
                    default:
                        for (int i = 0; i < NUM_LEDS; i++)
                            if (w_duty_sel[i]) r_duty[i] <= wbs.wbs_writedata[PWM_BITS-1:0];
                endcase
            end
        end
    end

    assign wbs.wbs_ack      = r_ack;
    assign wbs.wbs_readdata = r_rdata;
    assign bar_graph        = r_bar;
endmodule

// File: tb/tb_bar_graph_pwm_wb.sv
// Directed and randomized bench for bar_graph_pwm_wb against a cycle-stepped behavioural model.
module tb_bar_graph_pwm_wb;
    import bar_graph_pkg::*;

    localparam int AW       = 4;
    localparam int DW       = 16;
    localparam int NL       = 8;
    localparam int PB       = 8;
    localparam int PW       = 16;
    localparam int CNT_MOD  = 1 << PB;
    localparam int LED_MASK = (1 << NL) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NL-1:0] bar_graph;

    bar_graph_pwm_wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wbs ();

    bar_graph_pwm_wb #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LEDS(NL), .PWM_BITS(PB), .PRESCALE_WIDTH(PW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bar_graph (bar_graph),
        .wbs       (wbs)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural registers and timebase as plain integers.
    int m_en, m_mode, m_pat, m_psc, m_pc, m_cnt, m_phase, m_chase, m_ack, m_rdata, m_bar;
    int m_duty [NL];
    int q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_en = 0; m_mode = 0; m_pat = 0; m_psc = 0; m_pc = 0; m_cnt = 0;
        m_phase = 0; m_chase = 0; m_ack = 0; m_rdata = 0; m_bar = 0;
        for (int i = 0; i < NL; i++) m_duty[i] = 0;
    endfunction

    function automatic int rotl(input int c);
        return ((c << 1) | (c >> (NL - 1))) & LED_MASK;
    endfunction

    function automatic int reg_value(input int a);
        if (a == REG_CTRL)     return m_en | (m_mode << 1);
        if (a == REG_PATTERN)  return m_pat;
        if (a == REG_PRESCALE) return m_psc;
        if (a == REG_STATUS)   return m_cnt | (m_phase << PB);
        if (a >= REG_DUTY_BASE && a < REG_DUTY_BASE + NL) return m_duty[a - REG_DUTY_BASE];
        return 0;
    endfunction

    function automatic int exp_bar();
        int b = 0;
        if (m_en == 0) return 0;
        case (m_mode)
            0: b = m_pat;
            1: for (int i = 0; i < NL; i++)
                   if (((m_pat >> i) & 1) == 1 && m_duty[i] > m_cnt) b |= (1 << i);
            2: b = (m_phase != 0) ? m_pat : 0;
            default: b = m_chase;
        endcase
        return b;
    endfunction

    // Advance the model by one clock using the bus inputs now applied, then compare after the edge.
    task automatic step();
        int a, d, nb, rd, old_mode;
        bit req, we, tick, wrap;
        a   = int'(wbs.wbs_address);
        d   = int'(wbs.wbs_writedata);
        we  = wbs.wbs_write;
        req = wbs.wbs_cycle && wbs.wbs_strobe && (m_ack == 0);
        if (!reset) begin
            model_reset();
        end else begin
            nb       = exp_bar();
            rd       = reg_value(a);
            tick     = (m_en != 0) && (m_pc == m_psc);
            wrap     = tick && (m_cnt == CNT_MOD - 1);
            old_mode = m_mode;
            if (m_en == 0) begin
                m_pc = 0; m_cnt = 0;
            end else begin
                m_cnt = (m_cnt + int'(tick)) % CNT_MOD;
                m_pc  = (tick || (req && we && a == REG_PRESCALE)) ? 0 : m_pc + 1;
            end
            if (wrap) begin
                m_phase = 1 - m_phase;
                m_chase = rotl(m_chase);
            end
            if (req && we) begin
                if (a == REG_CTRL) begin
                    m_en = d & 1; m_mode = (d >> 1) & 3;
                    if (m_mode == 3) m_chase = m_pat;
                end else if (a == REG_PATTERN) begin
                    m_pat = d & LED_MASK;
                    if (old_mode == 3) m_chase = m_pat;
                end else if (a == REG_PRESCALE) begin
                    m_psc = d & ((1 << PW) - 1);
                end else if (a >= REG_DUTY_BASE && a < REG_DUTY_BASE + NL) begin
                    m_duty[a - REG_DUTY_BASE] = d & (CNT_MOD - 1);
                end
            end
            if (req && !we) m_rdata = rd;
            m_ack = int'(req);
            m_bar = nb;
        end
        @(posedge clk);
        #1;
        check("bar_graph", 32'(bar_graph), m_bar);
        check("ack", 32'(wbs.wbs_ack), m_ack);
        check("readdata", 32'(wbs.wbs_readdata), m_rdata);
    endtask

    task automatic bus_idle();
        wbs.wbs_cycle = 1'b0; wbs.wbs_strobe = 1'b0; wbs.wbs_write = 1'b0;
        wbs.wbs_address = '0; wbs.wbs_writedata = '0;
    endtask

    task automatic xfer(input int a, input int d, input bit we, output int rd);
        wbs.wbs_address   = AW'(a);
        wbs.wbs_writedata = DW'(d);
        wbs.wbs_write     = we;
        wbs.wbs_cycle     = 1'b1;
        wbs.wbs_strobe    = 1'b1;
        step();
        check("xfer_ack", 32'(wbs.wbs_ack), 1);
        rd = int'(wbs.wbs_readdata);
        bus_idle();
        step();
    endtask

    initial begin
        int rd, s1, s2, cnt0, cnt7, last, acks, a, d;
        bus_idle();
        model_reset();
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        check("reset_bar", 32'(bar_graph), 0);

        for (int i = 0; i < 16; i++) begin
            xfer(i, 0, 1'b0, rd);
            check("reset_read", rd, 0);
        end

        // Static mode
        xfer(REG_PATTERN, 'hA5, 1'b1, rd);
        xfer(REG_CTRL, 'h1, 1'b1, rd);
        check("static_bar", 32'(bar_graph), 'hA5);
        xfer(REG_PATTERN, 0, 1'b0, rd);
        check("pattern_readback", rd, 'h00A5);

        // PWM mode
        xfer(REG_PATTERN, 'hFF, 1'b1, rd);
        xfer(REG_DUTY_BASE, 'h40, 1'b1, rd);
        xfer(REG_DUTY_BASE + 7, 'h00, 1'b1, rd);
        xfer(REG_CTRL, 'h3, 1'b1, rd);
        xfer(REG_PRESCALE, 0, 1'b1, rd);
        xfer(REG_STATUS, 0, 1'b0, s1);
        xfer(REG_STATUS, 0, 1'b0, s2);
        check("status_step", (s2 - s1) & (CNT_MOD - 1), 2);
        cnt0 = 0; cnt7 = 0;
        for (int k = 0; k < CNT_MOD; k++) begin
            step();
            cnt0 += int'(bar_graph[0]);
            cnt7 += int'(bar_graph[7]);
        end
        check("pwm_duty40_count", cnt0, 64);
        check("pwm_duty0_count", cnt7, 0);
        for (int i = 1; i < NL - 1; i++) xfer(REG_DUTY_BASE + i, int'($urandom_range(0, 255)), 1'b1, rd);
        repeat (300) step();

        // Blink mode, PRESCALE=1
        xfer(REG_CTRL, 0, 1'b1, rd);
        xfer(REG_PRESCALE, 1, 1'b1, rd);
        xfer(REG_CTRL, 'h5, 1'b1, rd);
        q.delete();
        last = int'(bar_graph);
        for (int k = 0; k < 1200; k++) begin
            step();
            if (int'(bar_graph) != last) q.push_back(k);
            last = int'(bar_graph);
        end
        check("blink_toggles", 32'(q.size() >= 2), 1);
        check("blink_period", (q.size() >= 2) ? q[1] - q[0] : -1, 512);

        // Chase mode, PATTERN=0x81
        xfer(REG_CTRL, 0, 1'b1, rd);
        xfer(REG_PRESCALE, 0, 1'b1, rd);
        xfer(REG_PATTERN, 'h81, 1'b1, rd);
        xfer(REG_CTRL, 'h7, 1'b1, rd);
        check("chase_start", 32'(bar_graph), 'h81);
        q.delete();
        last = int'(bar_graph);
        for (int k = 0; k < 8 * CNT_MOD + 16; k++) begin
            step();
            if (int'(bar_graph) != last) q.push_back(int'(bar_graph));
            last = int'(bar_graph);
        end
        check("chase_steps", q.size(), 8);
        check("chase_1", (q.size() > 0) ? q[0] : -1, 'h03);
        check("chase_2", (q.size() > 1) ? q[1] : -1, 'h06);
        check("chase_8", (q.size() > 7) ? q[7] : -1, 'h81);

        // PATTERN write landing on the wrap edge: the write wins over the rotate
        for (int k = 0; k < 300 && m_cnt != CNT_MOD - 1; k++) step();
        check("wrap_found", m_cnt, CNT_MOD - 1);
        xfer(REG_PATTERN, 'h3C, 1'b1, rd);
        check("wrap_write_wins", 32'(bar_graph), 'h3C);

        // Unmapped and read-only writes are ignored
        xfer(15, 'hFFFF, 1'b1, rd);
        xfer(REG_STATUS, 'hFFFF, 1'b1, rd);
        xfer(REG_PATTERN, 0, 1'b0, rd);
        check("unmapped_pattern", rd, 'h3C);
        xfer(REG_CTRL, 0, 1'b0, rd);
        check("unmapped_ctrl", rd, 'h7);
        xfer(15, 0, 1'b0, rd);
        check("unmapped_read", rd, 0);

        // Randomized register traffic
        for (int n = 0; n < 60; n++) begin
            a = int'($urandom_range(0, 15));
            d = int'($urandom & 32'hFFFF);
            if (a == REG_PRESCALE) d = d & 3;
            if (a == REG_CTRL)     d = d & 7;
            xfer(a, d, 1'($urandom_range(0, 1)), rd);
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (50) step();

        // Back-to-back requests are acked every other cycle
        wbs.wbs_address = AW'(REG_PATTERN); wbs.wbs_write = 1'b0;
        wbs.wbs_cycle = 1'b1; wbs.wbs_strobe = 1'b1;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            acks += int'(wbs.wbs_ack);
        end
        check("b2b_acks", acks, 3);
        bus_idle();
        step();

        // Reset while a write request is pending
        wbs.wbs_address = AW'(REG_PATTERN); wbs.wbs_writedata = DW'('h55);
        wbs.wbs_write = 1'b1; wbs.wbs_cycle = 1'b1; wbs.wbs_strobe = 1'b1;
        reset = 1'b0;
        step();
        check("midrst_ack", 32'(wbs.wbs_ack), 0);
        check("midrst_bar", 32'(bar_graph), 0);
        bus_idle();
        reset = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            xfer(i, 0, 1'b0, rd);
            check("post_reset_read", rd, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
